axil_cmd_master: RTL and testbench

AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

---
 rtl/axil_cmd_master.sv | 215 +++++++++++++++++++++
 tb/tb_axil_cmd_master.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_cmd_master.sv
// AXI-Lite command master: programs accelerator dims, starts it, polls DONE, clears START.
// Optional bounded polling is compiled in with `define AXIL_CMD_MASTER_TIMEOUT_EN.
module axil_cmd_master #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       POLL_GAP  = 4,
  parameter int unsigned       POLL_MAX  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [DATA_W-1:0] cmd_m_i,
  input  logic [DATA_W-1:0] cmd_k_i,
  input  logic [DATA_W-1:0] cmd_n_i,
  output logic              m_axi_awvalid_o,
  input  logic              m_axi_awready_i,
  output logic [ADDR_W-1:0] m_axi_awaddr_o,
  output logic              m_axi_wvalid_o,
  input  logic              m_axi_wready_i,
  output logic [DATA_W-1:0] m_axi_wdata_o,
  input  logic              m_axi_bvalid_i,
  output logic              m_axi_bready_o,
  input  logic [1:0]        m_axi_bresp_i,
  output logic              m_axi_arvalid_o,
  input  logic              m_axi_arready_i,
  output logic [ADDR_W-1:0] m_axi_araddr_o,
  input  logic              m_axi_rvalid_i,
  output logic              m_axi_rready_o,
  input  logic [DATA_W-1:0] m_axi_rdata_i,
  input  logic [1:0]        m_axi_rresp_i,
  output logic              busy_o,
  output logic              job_done_o,
  output logic              job_err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_POLL_WAIT, S_CLR, S_FINISH
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] m;
    logic [DATA_W-1:0] k;
    logic [DATA_W-1:0] n;
  } dims_t;

  // Write index 0..3 is the programming sequence; IDX_CLR is the START=0 write.
  localparam logic [2:0] IDX_LAST = 3'd3;
  localparam logic [2:0] IDX_CLR  = 3'd4;
  localparam logic [7:0] GAP_LAST = (POLL_GAP == 0) ? 8'd0 : 8'(POLL_GAP - 1);

  state_e     state_q, state_d;
  dims_t      dims_q, dims_d;
  logic [2:0] idx_q, idx_d;
  logic       aw_pend_q, aw_pend_d;
  logic       w_pend_q, w_pend_d;
  logic       err_q, err_d;
  logic [7:0] gap_q, gap_d;
  logic [ADDR_W-1:0] wr_off;

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
  localparam int unsigned PCW = $clog2(POLL_MAX + 1);
  logic [PCW-1:0] poll_q, poll_d;
`else
  if (POLL_MAX == 0) begin : g_poll_max_unused
  end
`endif

  logic unused_rdata;
  assign unused_rdata = ^m_axi_rdata_i[DATA_W-1:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      dims_q    <= '0;
      idx_q     <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      err_q     <= 1'b0;
      gap_q     <= '0;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
      poll_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      dims_q    <= dims_d;
      idx_q     <= idx_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      err_q     <= err_d;
      gap_q     <= gap_d;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
      poll_q    <= poll_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    dims_d    = dims_q;
    idx_d     = idx_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    err_d     = err_q;
    gap_d     = gap_q;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    poll_d    = poll_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          dims_d.m  = cmd_m_i;
          dims_d.k  = cmd_k_i;
          dims_d.n  = cmd_n_i;
          idx_d     = '0;
          err_d     = 1'b0;
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
          poll_d    = '0;
`endif
          state_d   = S_WR;
        end
      end
      S_WR: begin
        // AW and W retire independently; move on once both have been taken.
        if (m_axi_awready_i) aw_pend_d = 1'b0;
        if (m_axi_wready_i)  w_pend_d  = 1'b0;
        if (!aw_pend_d && !w_pend_d) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (m_axi_bvalid_i) begin
          if (m_axi_bresp_i != 2'b00) begin
            err_d   = 1'b1;
            state_d = S_FINISH;
          end else if (idx_q == IDX_CLR) begin
            state_d = S_FINISH;
          end else if (idx_q == IDX_LAST) begin
            state_d = S_RD_ADDR;
          end else begin
            idx_d     = idx_q + 3'd1;
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            state_d   = S_WR;
          end
        end
      end
      S_RD_ADDR: begin
        if (m_axi_arready_i) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (m_axi_rvalid_i) begin
          if (m_axi_rresp_i != 2'b00) begin
            err_d   = 1'b1;
            state_d = S_FINISH;
          end else if (m_axi_rdata_i[0]) begin
            state_d = S_CLR;
          end else begin
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
            if (poll_q == PCW'(POLL_MAX - 1)) begin
              err_d   = 1'b1;
              state_d = S_FINISH;
            end else begin
              poll_d  = poll_q + 1'b1;
              gap_d   = '0;
              state_d = S_POLL_WAIT;
            end
`else
            gap_d   = '0;
            state_d = S_POLL_WAIT;
`endif
          end
        end
      end
      S_POLL_WAIT: begin
        if (gap_q >= GAP_LAST) state_d = S_RD_ADDR;
        else                   gap_d   = gap_q + 8'd1;
      end
      S_CLR: begin
        idx_d     = IDX_CLR;
        aw_pend_d = 1'b1;
        w_pend_d  = 1'b1;
        state_d   = S_WR;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_off        = '0;
    m_axi_wdata_o = '0;
    case (idx_q)
      3'd0:    begin wr_off = ADDR_W'(32'h08); m_axi_wdata_o = dims_q.m; end
      3'd1:    begin wr_off = ADDR_W'(32'h0C); m_axi_wdata_o = dims_q.k; end
      3'd2:    begin wr_off = ADDR_W'(32'h10); m_axi_wdata_o = dims_q.n; end
      3'd3:    begin wr_off = ADDR_W'(32'h00); m_axi_wdata_o = DATA_W'(1); end
      default: begin wr_off = ADDR_W'(32'h00); m_axi_wdata_o = '0; end
    endcase
  end

  assign m_axi_awaddr_o  = BASE_ADDR + wr_off;
  assign m_axi_awvalid_o = aw_pend_q;
  assign m_axi_wvalid_o  = w_pend_q;
  assign m_axi_bready_o  = (state_q == S_WR_RESP);
  assign m_axi_arvalid_o = (state_q == S_RD_ADDR);
  assign m_axi_araddr_o  = BASE_ADDR + ADDR_W'(32'h04);
  assign m_axi_rready_o  = (state_q == S_RD_DATA);
  assign cmd_ready_o     = (state_q == S_IDLE);
  assign busy_o          = (state_q != S_IDLE);
  assign job_done_o      = (state_q == S_FINISH);
  assign job_err_o       = (state_q == S_FINISH) && err_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Scoreboard bench: jobs push expected AXI writes/reads/completions; a monitor pops on handshakes.
module tb_axil_cmd_master;
  localparam logic [31:0] A_START = 32'h4000_0000;
  localparam logic [31:0] A_DONE  = 32'h4000_0004;
  localparam logic [31:0] A_M     = 32'h4000_0008;
  localparam logic [31:0] A_K     = 32'h4000_000C;
  localparam logic [31:0] A_N     = 32'h4000_0010;
  localparam int K_W = 0, K_R = 1, K_D = 2;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    int          awc;
    int          wc;
  } ev_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [31:0] cmd_m = '0, cmd_k = '0, cmd_n = '0;
  logic awvalid, awready = 1'b0, wvalid, wready = 1'b0, bvalid = 1'b0, bready;
  logic [31:0] awaddr, wdata, araddr, rdata = '0;
  logic [1:0] bresp = 2'b00, rresp = 2'b00;
  logic arvalid, arready = 1'b0, rvalid = 1'b0, rready;
  logic busy, job_done, job_err;

  int n_cmp = 0, n_bad = 0;
  ev_t expq[$];

  // slave knobs and state
  int aw_delay = 0, w_delay = 0, aw_wait = 0, w_wait = 0, done_at = 0, rd_n = 0;
  logic err_en = 1'b0;
  logic [31:0] err_addr = '0, s_awaddr = '0;
  logic got_aw = 1'b0, got_w = 1'b0, got_ar = 1'b0, b_done = 1'b0, r_done = 1'b0;

  // monitor state
  logic mon_aw = 1'b0, mon_w = 1'b0;
  logic [31:0] mon_awaddr = '0, mon_wdata = '0;
  int aw_cnt = 0, w_cnt = 0;

  always #5 clk = ~clk;

  axil_cmd_master #(
    .ADDR_W(32), .DATA_W(32), .BASE_ADDR(32'h4000_0000), .POLL_GAP(2), .POLL_MAX(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_m_i(cmd_m), .cmd_k_i(cmd_k), .cmd_n_i(cmd_n),
    .m_axi_awvalid_o(awvalid), .m_axi_awready_i(awready), .m_axi_awaddr_o(awaddr),
    .m_axi_wvalid_o(wvalid), .m_axi_wready_i(wready), .m_axi_wdata_o(wdata),
    .m_axi_bvalid_i(bvalid), .m_axi_bready_o(bready), .m_axi_bresp_i(bresp),
    .m_axi_arvalid_o(arvalid), .m_axi_arready_i(arready), .m_axi_araddr_o(araddr),
    .m_axi_rvalid_i(rvalid), .m_axi_rready_o(rready), .m_axi_rdata_i(rdata), .m_axi_rresp_i(rresp),
    .busy_o(busy), .job_done_o(job_done), .job_err_o(job_err)
  );

  // Slave: note handshakes at negedge, update its drives just after posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      got_aw = 1'b0; got_w = 1'b0; got_ar = 1'b0; b_done = 1'b0; r_done = 1'b0;
    end else begin
      if (awvalid && awready) begin got_aw = 1'b1; s_awaddr = awaddr; end
      if (wvalid && wready)   got_w  = 1'b1;
      if (bvalid && bready)   b_done = 1'b1;
      if (arvalid && arready) begin got_ar = 1'b1; rd_n++; end
      if (rvalid && rready)   r_done = 1'b1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
      aw_wait = 0; w_wait = 0;
    end else begin
      if (awvalid) begin awready = (aw_wait >= aw_delay); aw_wait++; end
      else begin awready = 1'b0; aw_wait = 0; end
      if (wvalid) begin wready = (w_wait >= w_delay); w_wait++; end
      else begin wready = 1'b0; w_wait = 0; end
      if (b_done) begin bvalid = 1'b0; b_done = 1'b0; end
      if (got_aw && got_w) begin
        bvalid = 1'b1;
        bresp  = (err_en && s_awaddr == err_addr) ? 2'b10 : 2'b00;
        got_aw = 1'b0; got_w = 1'b0;
      end
      arready = arvalid;
      if (r_done) begin rvalid = 1'b0; r_done = 1'b0; end
      if (got_ar) begin
        rvalid = 1'b1;
        rdata  = (done_at != 0 && rd_n >= done_at) ? 32'd1 : 32'd0;
        rresp  = 2'b00;
        got_ar = 1'b0;
      end
    end
  end

  task automatic check_ev(input int kind, input logic [31:0] a, input logic [31:0] d,
                          input int awc, input int wc, input string nm);
    ev_t e;
    n_cmp++;
    if (expq.size() == 0) begin
      n_bad++;
      $display("FAIL %s: unexpected event kind=%0d addr=%h data=%h", nm, kind, a, d);
      return;
    end
    e = expq.pop_front();
    if (e.kind != kind || e.addr != a || e.data != d ||
        (e.awc != 0 && e.awc != awc) || (e.wc != 0 && e.wc != wc)) begin
      n_bad++;
      $display("FAIL %s: got kind=%0d addr=%h data=%h awcyc=%0d wcyc=%0d, want kind=%0d addr=%h data=%h awcyc=%0d wcyc=%0d",
               nm, kind, a, d, awc, wc, e.kind, e.addr, e.data, e.awc, e.wc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_aw = 1'b0; mon_w = 1'b0; aw_cnt = 0; w_cnt = 0;
    end else begin
      if (awvalid) aw_cnt++;
      if (wvalid)  w_cnt++;
      n_cmp++;
      if (cmd_ready == busy) begin
        n_bad++;
        $display("FAIL ready_vs_busy: cmd_ready=%b busy=%b", cmd_ready, busy);
      end
      if (awvalid && awready) begin
        if (mon_aw) begin n_bad++; $display("FAIL aw_dup: second AW addr=%h before B", awaddr); end
        mon_aw = 1'b1; mon_awaddr = awaddr;
      end
      if (wvalid && wready) begin
        if (mon_w) begin n_bad++; $display("FAIL w_dup: second W data=%h before B", wdata); end
        mon_w = 1'b1; mon_wdata = wdata;
      end
      if (bvalid && bready) begin
        if (!(mon_aw && mon_w)) begin
          n_bad++; $display("FAIL b_early: B accepted with aw=%b w=%b", mon_aw, mon_w);
        end
        check_ev(K_W, mon_awaddr, mon_wdata, aw_cnt, w_cnt, "write");
        mon_aw = 1'b0; mon_w = 1'b0; aw_cnt = 0; w_cnt = 0;
      end
      if (arvalid) begin
        n_cmp++;
        if (awvalid || wvalid || mon_aw || mon_w) begin
          n_bad++; $display("FAIL overlap: arvalid=1 with write pending aw=%b w=%b", awvalid, wvalid);
        end
        if (arready) check_ev(K_R, araddr, 32'd0, 0, 0, "read");
      end
      if (job_done) check_ev(K_D, 32'd0, {31'd0, job_err}, 0, 0, "done");
    end
  end

  task automatic push(input int kind, input logic [31:0] a, input logic [31:0] d, input int awc, input int wc);
    ev_t e;
    e.kind = kind; e.addr = a; e.data = d; e.awc = awc; e.wc = wc;
    expq.push_back(e);
  endtask

  task automatic push_job(input logic [31:0] m, input logic [31:0] k, input logic [31:0] n,
                          input int nrd, input int awc, input int wc);
    push(K_W, A_M, m, awc, wc);
    push(K_W, A_K, k, awc, wc);
    push(K_W, A_N, n, awc, wc);
    push(K_W, A_START, 32'd1, awc, wc);
    for (int i = 0; i < nrd; i++) push(K_R, A_DONE, 32'd0, 0, 0);
    push(K_W, A_START, 32'd0, awc, wc);
    push(K_D, 32'd0, 32'd0, 0, 0);
  endtask

  task automatic send_cmd(input logic [31:0] m, input logic [31:0] k, input logic [31:0] n);
    bit ok = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_m = m; cmd_k = k; cmd_n = n;
    for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); ok = cmd_ready; end
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_m = 32'hDEAD_BEEF; cmd_k = 32'hDEAD_BEEF; cmd_n = 32'hDEAD_BEEF;
    if (!ok) begin n_cmp++; n_bad++; $display("FAIL cmd_accept: cmd_ready=0 want 1"); end
  endtask

  task automatic wait_idle(input int budget, input string nm);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = (expq.size() == 0) && !busy;
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: %0d events outstanding busy=%b", nm, expq.size(), busy);
      expq.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] outs;
    bit ok;
    // Reset state
    #23;
    outs = {awvalid, wvalid, bready, arvalid, rready, busy, job_done, job_err};
    n_cmp++;
    if (outs != 8'h00) begin n_bad++; $display("FAIL reset_outs: got %b want 00000000", outs); end
    @(posedge clk); #3; rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end

    // Basic job, slave always ready, DONE on 3rd read
    done_at = 3; rd_n = 0;
    push_job(32'd2, 32'd2, 32'd2, 3, 1, 1);
    send_cmd(32'd2, 32'd2, 32'd2);
    wait_idle(400, "basic");

    // AW stalls 3 cycles, W immediate
    aw_delay = 3; w_delay = 0; done_at = 1; rd_n = 0;
    push_job(32'd5, 32'd6, 32'd7, 1, 4, 1);
    send_cmd(32'd5, 32'd6, 32'd7);
    wait_idle(400, "aw_stall");

    // W stalls 2 cycles, AW immediate; error response on CFG_K
    aw_delay = 0; w_delay = 2; err_en = 1'b1; err_addr = A_K;
    push(K_W, A_M, 32'd1, 1, 3);
    push(K_W, A_K, 32'd9, 1, 3);
    push(K_D, 32'd0, 32'd1, 0, 0);
    send_cmd(32'd1, 32'd9, 32'd3);
    wait_idle(400, "bresp_err");
    err_en = 1'b0; w_delay = 0;
    repeat (5) @(negedge clk);

    // Reset during RD_DATA, then a fresh job
    done_at = 0; rd_n = 0;
    push(K_W, A_M, 32'd4, 0, 0);
    push(K_W, A_K, 32'd4, 0, 0);
    push(K_W, A_N, 32'd4, 0, 0);
    push(K_W, A_START, 32'd1, 0, 0);
    push(K_R, A_DONE, 32'd0, 0, 0);
    send_cmd(32'd4, 32'd4, 32'd4);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk); ok = rready; end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL reach_rd_data: rready never seen"); end
    #2; rst_n = 1'b0; #1;
    outs = {awvalid, wvalid, bready, arvalid, rready, busy, job_done, job_err};
    n_cmp++;
    if (outs != 8'h00) begin n_bad++; $display("FAIL async_reset: got %b want 00000000", outs); end
    n_cmp++;
    if (expq.size() != 0) begin
      n_bad++; $display("FAIL pre_reset_events: %0d outstanding want 0", expq.size()); expq.delete();
    end
    repeat (3) @(posedge clk);
    #3; rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({awvalid, wvalid, arvalid, busy, cmd_ready} != 5'b00001) begin
        n_bad++;
        $display("FAIL post_reset_quiet: aw=%b w=%b ar=%b busy=%b ready=%b want 0 0 0 0 1",
                 awvalid, wvalid, arvalid, busy, cmd_ready);
      end
    end
    done_at = 2; rd_n = 0;
    push_job(32'd1, 32'd3, 32'd1, 2, 1, 1);
    send_cmd(32'd1, 32'd3, 32'd1);
    wait_idle(400, "after_reset");

    // cmd_valid held across a job: second job waits, first job keeps its dims
    done_at = 1; rd_n = 0;
    push_job(32'd3, 32'd1, 32'd2, 1, 1, 1);
    push_job(32'd7, 32'd8, 32'd9, 1, 1, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_m = 32'd3; cmd_k = 32'd1; cmd_n = 32'd2;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); ok = cmd_ready; end
    @(posedge clk); #1;
    cmd_m = 32'd7; cmd_k = 32'd8; cmd_n = 32'd9;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin @(negedge clk); ok = job_done; end
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); ok = cmd_ready; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL held_cmd: cmd_ready not seen after first job_done"); end
    wait_idle(400, "held_cmd");

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    // DONE never set: exactly POLL_MAX reads then error, no clear write
    done_at = 0; rd_n = 0;
    push(K_W, A_M, 32'd1, 1, 1);
    push(K_W, A_K, 32'd1, 1, 1);
    push(K_W, A_N, 32'd1, 1, 1);
    push(K_W, A_START, 32'd1, 1, 1);
    for (int i = 0; i < 4; i++) push(K_R, A_DONE, 32'd0, 0, 0);
    push(K_D, 32'd0, 32'd1, 0, 0);
    send_cmd(32'd1, 32'd1, 32'd1);
    wait_idle(400, "timeout");
`endif

    repeat (10) @(negedge clk);
    n_cmp++;
    if (expq.size() != 0) begin n_bad++; $display("FAIL leftover: %0d events want 0", expq.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
